// File: rtl/rr_bus_scheduler_if.sv
// Bundle between the requesting masters and the round-robin bus scheduler.
// The masters drive req; the scheduler drives the grant/owner/status signals.
interface rr_bus_scheduler_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       bus_busy;
  logic       preempt;
  logic [7:0] preempt_count;

  modport master (
    output req,
    input  grant,
    input  grant_id,
    input  bus_busy,
    input  preempt,
    input  preempt_count
  );

  modport slave (
    input  req,
    output grant,
    output grant_id,
    output bus_busy,
    output preempt,
    output preempt_count
  );
endinterface

// File: rtl/rr_bus_scheduler.sv
// Four-master shared-bus scheduler: rotating priority, bounded tenure with
// preemption, and a one-cycle turnaround between owners.
module rr_bus_scheduler #(
  parameter int MAX_HOLD = 8
) (
  input  logic               clock,
  input  logic               reset,
  rr_bus_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIMIT = MAX_HOLD[7:0];
  localparam bit         UNLIMITED  = (MAX_HOLD == 0);

  state_t     state, state_next;
  logic [3:0] grant, grant_next;
  logic [1:0] grant_id, grant_id_next;
  logic [1:0] last_id, last_id_next;
  logic [7:0] hold_cnt, hold_cnt_next;
  logic       bus_busy, bus_busy_next;
  logic       preempt, preempt_next;
  logic [7:0] preempt_count, preempt_count_next;

  logic       win_found;
  logic [1:0] win_id;
  logic [1:0] cand;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

  // Rotating search: starts just after the previous owner, so it ranks last.
  always_comb begin
    win_found = 1'b0;
    win_id    = 2'd0;
    cand      = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_id + 2'(i);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_next         = state;
    grant_next         = grant;
    grant_id_next      = grant_id;
    last_id_next       = last_id;
    hold_cnt_next      = hold_cnt;
    preempt_next       = 1'b0;
    preempt_count_next = preempt_count;

    unique case (state)
      IDLE, TURN: begin
        if (win_found) begin
          state_next    = GRANT;
          grant_next    = 4'b0001 << win_id;
          grant_id_next = win_id;
          last_id_next  = win_id;
          hold_cnt_next = 8'd1;
        end else begin
          state_next = IDLE;
          grant_next = 4'b0000;
        end
      end
      GRANT: begin
        // A request drop wins over the tenure limit on the same edge.
        if (!bus.req[grant_id]) begin
          state_next = TURN;
          grant_next = 4'b0000;
        end else if (!UNLIMITED && (hold_cnt == HOLD_LIMIT)) begin
          state_next         = TURN;
          grant_next         = 4'b0000;
          preempt_next       = 1'b1;
          preempt_count_next = sat_inc8(preempt_count);
        end else begin
          hold_cnt_next = sat_inc8(hold_cnt);
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 4'b0000;
      end
    endcase

    bus_busy_next = (grant_next != 4'b0000);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= 4'b0000;
      grant_id      <= 2'd0;
      last_id       <= 2'd3;
      hold_cnt      <= 8'd0;
      bus_busy      <= 1'b0;
      preempt       <= 1'b0;
      preempt_count <= 8'd0;
    end else begin
      state         <= state_next;
      grant         <= grant_next;
      grant_id      <= grant_id_next;
      last_id       <= last_id_next;
      hold_cnt      <= hold_cnt_next;
      bus_busy      <= bus_busy_next;
      preempt       <= preempt_next;
      preempt_count <= preempt_count_next;
    end
  end

  assign bus.grant         = grant;
  assign bus.grant_id      = grant_id;
  assign bus.bus_busy      = bus_busy;
  assign bus.preempt       = preempt;
  assign bus.preempt_count = preempt_count;

endmodule

// File: tb/tb_rr_bus_scheduler.sv
// Bench for rr_bus_scheduler: a MAX_HOLD=4 and a MAX_HOLD=0 instance checked
// every cycle against an ownership-level reference model plus directed checks.
module tb_rr_bus_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  rr_bus_scheduler_if bus4 ();
  rr_bus_scheduler_if bus0 ();

  rr_bus_scheduler #(.MAX_HOLD(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4));
  rr_bus_scheduler #(.MAX_HOLD(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));

  typedef struct {
    int owner;   // -1 when nobody holds the bus
    int tenure;  // cycles the current owner has held the grant
    int last;    // most recent owner, lowest priority next time
    int pcount;
    bit pre;
  } model_t;

  model_t m4, m0;
  int checks = 0;
  int failures = 0;

  function automatic model_t model_reset();
    model_t s;
    s.owner = -1; s.tenure = 0; s.last = 3; s.pcount = 0; s.pre = 1'b0;
    return s;
  endfunction

  function automatic model_t model_step(model_t s, logic [3:0] r, int mh);
    model_t n = s;
    int best, bestd, d;
    n.pre = 1'b0;
    if (s.owner >= 0) begin
      if (!r[s.owner]) begin
        n.owner = -1;
      end else if (mh != 0 && s.tenure >= mh) begin
        n.owner  = -1;
        n.pre    = 1'b1;
        n.pcount = (s.pcount < 255) ? s.pcount + 1 : 255;
      end else begin
        n.tenure = (s.tenure < 255) ? s.tenure + 1 : 255;
      end
    end else begin
      best = -1; bestd = 99;
      for (int i = 0; i < 4; i++) begin
        d = (i - s.last - 1 + 8) % 4;
        if (r[i] && d < bestd) begin best = i; bestd = d; end
      end
      if (best >= 0) begin
        n.owner = best; n.last = best; n.tenure = 1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string name, input model_t s,
                             input logic [3:0] g, input logic [1:0] gid,
                             input logic busy, input logic pre, input logic [7:0] pc);
    logic [3:0] eg;
    eg = (s.owner >= 0) ? (4'b0001 << s.owner) : 4'b0000;
    chk({name, ".grant"}, 8'(g), 8'(eg));
    chk({name, ".bus_busy"}, 8'(busy), 8'(s.owner >= 0));
    chk({name, ".preempt"}, 8'(pre), 8'(s.pre));
    chk({name, ".preempt_count"}, pc, 8'(s.pcount));
    if (s.owner >= 0) chk({name, ".grant_id"}, 8'(gid), 8'(s.owner));
  endtask

  // One clock: model sees the inputs the DUT samples, outputs checked 1 ns later.
  task automatic cycle();
    @(posedge clock);
    if (reset) begin
      m4 = model_reset();
      m0 = model_reset();
    end else begin
      m4 = model_step(m4, bus4.req, 4);
      m0 = model_step(m0, bus0.req, 0);
    end
    #1;
    check_model("h4", m4, bus4.grant, bus4.grant_id, bus4.bus_busy, bus4.preempt, bus4.preempt_count);
    check_model("h0", m0, bus0.grant, bus0.grant_id, bus0.bus_busy, bus0.preempt, bus0.preempt_count);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    m4 = model_reset();
    m0 = model_reset();
    bus4.req = 4'b0000;
    bus0.req = 4'b0000;

    // Reset state
    do_reset();
    chk("reset.grant", 8'(bus4.grant), 8'h0);
    chk("reset.grant_id", 8'(bus4.grant_id), 8'h0);
    chk("reset.busy", 8'(bus4.bus_busy), 8'h0);
    chk("reset.count", bus4.preempt_count, 8'h0);

    // Single request, then voluntary drop
    bus4.req = 4'b0001;
    cycle();
    chk("single.grant", 8'(bus4.grant), 8'h01);
    chk("single.id", 8'(bus4.grant_id), 8'h0);
    chk("single.busy", 8'(bus4.bus_busy), 8'h1);
    bus4.req = 4'b0000;
    cycle();
    chk("single.drop", 8'(bus4.grant), 8'h00);
    cycle();

    // Full contention: 4-cycle tenures, 1-cycle turns, rotating owners
    do_reset();
    bus4.req = 4'b1111;
    for (int i = 0; i < 20; i++) cycle();
    chk("rot.count", bus4.preempt_count, 8'd4);
    chk("rot.preempt", 8'(bus4.preempt), 8'h1);
    chk("rot.turn", 8'(bus4.grant), 8'h00);
    cycle();
    chk("rot.wrap", 8'(bus4.grant), 8'h01);
    for (int i = 0; i < 12; i++) cycle();

    // Owner 2 preempted while 0 and 2 request: search wraps to 0
    do_reset();
    bus4.req = 4'b0100;
    cycle();
    chk("wrap.g2", 8'(bus4.grant), 8'h04);
    bus4.req = 4'b0101;
    for (int i = 0; i < 5; i++) cycle();
    chk("wrap.g0", 8'(bus4.grant), 8'h01);
    chk("wrap.id0", 8'(bus4.grant_id), 8'h0);

    // Master 1 drops on its 4th grant cycle: voluntary, no preempt
    do_reset();
    bus4.req = 4'b0010;
    for (int i = 0; i < 4; i++) cycle();
    bus4.req = 4'b0000;
    cycle();
    chk("vol.grant", 8'(bus4.grant), 8'h00);
    chk("vol.preempt", 8'(bus4.preempt), 8'h0);
    chk("vol.count", bus4.preempt_count, 8'h0);
    cycle();

    // Reset in the 2nd grant cycle of master 3 while 0 and 3 request
    do_reset();
    bus4.req = 4'b0001;
    cycle();
    bus4.req = 4'b0000;
    cycle();
    bus4.req = 4'b1000;
    cycle();
    chk("rst.g3", 8'(bus4.grant), 8'h08);
    bus4.req = 4'b1001;
    cycle();
    reset = 1'b1;
    cycle();
    chk("rst.grant", 8'(bus4.grant), 8'h00);
    chk("rst.preempt", 8'(bus4.preempt), 8'h0);
    reset = 1'b0;
    cycle();
    chk("rst.first", 8'(bus4.grant), 8'h01);

    // Randomized requests on both instances
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) bus4.req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) bus0.req = 4'($urandom);
      cycle();
    end

    // Unlimited tenure: master 1 holds for 300 cycles without preemption
    do_reset();
    bus4.req = 4'b0000;
    bus0.req = 4'b0010;
    for (int i = 0; i < 300; i++) cycle();
    chk("unl.grant", 8'(bus0.grant), 8'h02);
    chk("unl.count", bus0.preempt_count, 8'h0);
    bus0.req = 4'b0000;
    cycle();
    chk("unl.release", 8'(bus0.grant), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_bus_scheduler.md
# rr_bus_scheduler

Four-requester shared-bus scheduler with rotating priority, a bounded bus tenure, and a mandatory one-cycle turnaround between owners. It sits between the requesting masters and the shared bus. It gives one-hot grants plus an encoded owner ID to the bus mux. An owner that holds the bus longer than MAX_HOLD cycles is preempted, so no master can starve the others.

## Interface
- MAX_HOLD, 8: maximum consecutive grant cycles per tenure; 0 = unlimited; legal range 0..255
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- req  input  4  level request per master; held high while bus wanted
- grant  output  4  one-hot registered grant; all zero when bus unowned
- grant_id  output  2  encoded owner (valid only while bus_busy)
- bus_busy  output  1  high while any grant bit is high
- preempt  output  1  one-cycle pulse on the cycle after a forced release
- preempt_count  output  8  saturating count of preemptions since reset

## Operation
- States: IDLE, GRANT, TURN. Reset forces IDLE.
- Reset values: grant=0, grant_id=0, bus_busy=0, preempt=0, preempt_count=0, hold counter=0, last_id=3. With last_id=3, req[0] has highest priority after reset.
- Arbitration is done only in IDLE and at the end of TURN:
  - Search starts at (last_id+1) mod 4 and wraps upward.
  - The first asserted req wins.
  - On the next edge: the winner's grant bit is set, grant_id is set, last_id takes the winner, hold counter is loaded with 1, and the state goes to GRANT.
- If no req is asserted in IDLE or TURN, the state goes to (or stays in) IDLE.
- GRANT behaviour at each edge, evaluated in this priority order:
  1. req[grant_id]=0 means voluntary release. grant is cleared and the state goes to TURN. preempt does not pulse.
  2. MAX_HOLD≠0 and hold counter==MAX_HOLD means forced release. grant is cleared, preempt=1 for one cycle, preempt_count increments (sticks at 255), and the state goes to TURN.
  3. Otherwise the state stays in GRANT and the hold counter increments. With MAX_HOLD=0 the counter saturates at 255.
- TURN lasts exactly one cycle with grant=0. A preempted master that still requests competes normally. Because last_id points at it, it has the lowest priority.
- Requests from non-owners during GRANT are ignored, and no state is stored for them.
- grant is always one-hot or zero. It is never multi-hot.

## Timing
- Request to grant latency: req sampled high at edge k in IDLE gives grant visible after edge k (one cycle).
- Tenure is at most MAX_HOLD cycles with grant high. For example, MAX_HOLD=4 gives grant high for exactly 4 cycles, then 1 turnaround cycle with grant=0.
- Minimum gap between grants to different owners is 1 cycle (TURN). The same master can be re-granted after TURN if it is the only requester.
- Req dropping on the same edge that the limit is reached counts as a voluntary release. preempt stays 0.
- preempt rises in the first TURN cycle and falls on the next edge.
- Reset asserted mid-GRANT: on that edge grant goes to 0, preempt to 0, counters clear, and last_id returns to 3. No preempt pulse is generated.
- bus_busy and grant_id change on the same edge as grant.

## Test plan
- Reset, then req=0001: grant=0001 one cycle later, bus_busy=1, grant_id=0. Drop req: grant=0 next cycle, then IDLE.
- req=1111 held, MAX_HOLD=4: grants rotate 0001→0010→0100→1000→0001. Each tenure is 4 cycles, separated by 1 zero cycle. preempt pulses 4 times in each rotation, and preempt_count counts 1,2,3,….
- After a grant to master 2, assert req=0101 at the same time: the next grant goes to master 0 (search starts at 3, wraps to 0).
- MAX_HOLD=4, master 1 drops req on the 4th grant cycle: release with preempt=0 and preempt_count unchanged.
- MAX_HOLD=0, req=0010 held for 300 cycles: grant stays 0010 throughout and preempt never fires.
- Assert reset during the 2nd cycle of a grant to master 3 with req=1001: grant=0 after the reset edge. After reset releases, master 0 is granted first.
